// File: rtl/mux_skid_stage_if.sv
// Producer/consumer bundle for mux_skid_stage: selectable input words in, one selected word out.
// The slave modport is the stage itself; the master modport is whoever drives and drains it.
interface mux_skid_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) ();

    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

endinterface

// File: rtl/mux_skid_stage.sv
// Word-select mux followed by a two-entry (main + skid) register stage. in_ready is registered,
// so out_ready never reaches in_ready combinationally; the skid entry absorbs the one extra word.
module mux_skid_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mux_skid_stage_if.slave   bus
);

    // With a power-of-two N_IN every encodable sel is a valid index, so sel_err folds to 0.
    localparam bit AllInRange = ((1 << SEL_W) <= N_IN);

    logic [WIDTH-1:0] sel_data;
    logic             sel_oob;

    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (32'(bus.sel) == k) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oob = !AllInRange && (32'(bus.sel) >= N_IN);

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             sel_err_q, sel_err_d;

    logic accept;
    logic xfer;

    assign accept = bus.in_valid && in_ready_q && !bus.flush;
    assign xfer   = main_valid_q && bus.out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        main_sel_d   = main_sel_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q;

        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    main_sel_d   = skid_sel_q;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            // accept implies skid is empty, since in_ready mirrors !skid.valid
            if (accept) begin
                if (!main_valid_q || xfer) begin
                    main_data_d  = sel_data;
                    main_sel_d   = bus.sel;
                    main_valid_d = 1'b1;
                end else begin
                    skid_data_d  = sel_data;
                    skid_sel_d   = bus.sel;
                    skid_valid_d = 1'b1;
                end
                if (sel_oob) begin
                    sel_err_d = 1'b1;
                end
            end
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            main_data_q  <= '0;
            main_sel_q   <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            sel_err_q    <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_sel_q   <= main_sel_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;
    assign bus.out_valid = main_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.sel_err   = sel_err_q;

endmodule
